// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared sizes, FSM states and local-result codes for the divider front end
// Purpose: common definitions imported by div_clz and div_front.
// Contents: WIDTH / EXPWIDTH defaults, state_t (FSM states), local_t (results produced
//           without the iterative core).
package div_pkg;

  localparam int WIDTH    = 32;
  localparam int EXPWIDTH = 6;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // Results the front end answers by itself, without starting the core.
  typedef enum logic [1:0] {
    NONE,
    DIV0,
    OVF
  } local_t;

endpackage

// File: rtl/div_clz.sv
// rtl/div_clz.sv - combinational count-leading-zeros
// Purpose: number of leading zero bits of data, WIDTH when data is all zeros.
// Ports:
//   data  - input operand (WIDTH bits)
//   count - leading zero count, 0..WIDTH
module div_clz import div_pkg::*; #(
  parameter int WIDTH = div_pkg::WIDTH,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  // Scan upward so the most significant set bit is the last one to win.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/div_front.sv
// rtl/div_front.sv - request/response front end for an iterative divider core
// Purpose: accepts a divide request, resolves divide-by-zero and signed overflow locally,
//          otherwise normalizes the operands and hands them to the core, then returns the
//          core result on the response channel.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   req_*                  - request channel (valid/ready, dividend, divisor, signed)
//   rsp_*                  - response channel (valid/ready, quotient, remainder, div0, ovf)
//   core_start, core_*     - normalized operands and control toward the core
//   core_q/r/done/free     - core result, completion strobe and availability
module div_front import div_pkg::*; #(
  parameter int WIDTH    = div_pkg::WIDTH,
  parameter int EXPWIDTH = div_pkg::EXPWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [WIDTH-1:0]    req_dividend,
  input  logic [WIDTH-1:0]    req_divisor,
  input  logic                req_signed,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_q,
  output logic [WIDTH-1:0]    rsp_r,
  output logic                rsp_div0,
  output logic                rsp_ovf,
  output logic                core_start,
  output logic [WIDTH-1:0]    core_dividend_bn,
  output logic [WIDTH:0]      core_divisor_bn,
  output logic [WIDTH-1:0]    core_dividend,
  output logic [EXPWIDTH-1:0] core_cycle_num,
  output logic                core_pass_flag,
  output logic                core_zero_flag_divisor,
  output logic                core_dividend_sign,
  output logic                core_divisor_sign,
  output logic [EXPWIDTH:0]   core_divisor_bit,
  input  logic [WIDTH-1:0]    core_q,
  input  logic [WIDTH-1:0]    core_r,
  input  logic                core_done,
  input  logic                core_free
);

  localparam int LZW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] op_n, op_d;
  logic             op_signed;
  logic [LZW-1:0]   lz_n, lz_d;
  logic [LZW-1:0]   clz_n, clz_d;
  logic             sd, sv;
  logic [WIDTH-1:0] abs_n, abs_d;
  logic [WIDTH-1:0] sh_n, sh_d;
  local_t           local_code;
  logic             fields_en;

  assign sd    = op_n[WIDTH-1] & op_signed;
  assign sv    = op_d[WIDTH-1] & op_signed;
  assign abs_n = sd ? -op_n : op_n;
  assign abs_d = sv ? -op_d : op_d;

  div_clz #(.WIDTH(WIDTH)) u_clz_n (.data(abs_n), .count(clz_n));
  div_clz #(.WIDTH(WIDTH)) u_clz_d (.data(abs_d), .count(clz_d));

  always_comb begin
    local_code = NONE;
    if (op_d == '0) begin
      local_code = DIV0;
    end else if (op_signed && (op_n == MIN_NEG) && (op_d == '1)) begin
      local_code = OVF;
    end
  end

  assign req_ready  = (state == IDLE);
  // Start is qualified by core_free in the same cycle so the core never sees a start it
  // cannot take; the FSM leaves ISSUE on exactly that cycle, giving a single pulse.
  assign core_start = (state == ISSUE) & core_free;

  // Core fields are derived from registers that only change on accept and in PREP, so
  // they are stable across ISSUE and WAIT; outside those states they read as zero.
  assign fields_en = (state == ISSUE) || (state == WAIT);
  assign sh_n      = abs_n << lz_n;
  assign sh_d      = abs_d << lz_d;

  assign core_divisor_bn        = fields_en ? {1'b0, sh_d} : '0;
  assign core_dividend_bn       = fields_en ? (sh_n >> 2) : '0;
  assign core_divisor_bit       = fields_en ? (EXPWIDTH+1)'(lz_d) : '0;
  assign core_cycle_num         = fields_en ? (EXPWIDTH'(lz_d) - EXPWIDTH'(lz_n) + EXPWIDTH'(1)) : '0;
  assign core_dividend          = fields_en ? op_n : '0;
  assign core_pass_flag         = fields_en & (abs_n < abs_d);
  assign core_zero_flag_divisor = fields_en;
  assign core_dividend_sign     = fields_en & sd;
  assign core_divisor_sign      = fields_en & sv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_n      <= '0;
      op_d      <= '0;
      op_signed <= 1'b0;
      lz_n      <= '0;
      lz_d      <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_div0  <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_n      <= req_dividend;
            op_d      <= req_divisor;
            op_signed <= req_signed;
            state     <= PREP;
          end
        end
        PREP: begin
          lz_n <= clz_n;
          lz_d <= clz_d;
          unique case (local_code)
            DIV0: begin
              rsp_q     <= '1;
              rsp_r     <= op_n;
              rsp_div0  <= 1'b1;
              rsp_ovf   <= 1'b0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
            OVF: begin
              rsp_q     <= MIN_NEG;
              rsp_r     <= '0;
              rsp_div0  <= 1'b0;
              rsp_ovf   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
            default: state <= ISSUE;
          endcase
        end
        ISSUE: begin
          if (core_free) state <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            rsp_q     <= core_q;
            rsp_r     <= core_r;
            rsp_div0  <= 1'b0;
            rsp_ovf   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_front.sv
// tb/tb_div_front.sv - scoreboard bench for div_front with a behavioural core stub
module tb_div_front;
  import div_pkg::*;

  localparam int W = 32;
  localparam int E = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_signed;
  logic [W-1:0]  req_dividend, req_divisor;
  logic          rsp_valid, rsp_ready, rsp_div0, rsp_ovf;
  logic [W-1:0]  rsp_q, rsp_r;
  logic          core_start, core_pass_flag, core_zero_flag_divisor;
  logic          core_dividend_sign, core_divisor_sign;
  logic [W-1:0]  core_dividend_bn, core_dividend;
  logic [W:0]    core_divisor_bn;
  logic [E-1:0]  core_cycle_num;
  logic [E:0]    core_divisor_bit;
  logic [W-1:0]  core_q, core_r;
  logic          core_done, core_free;
  logic          outs_any;

  always #5 clk = ~clk;

  div_front #(.WIDTH(W), .EXPWIDTH(E)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_dividend(req_dividend),
    .req_divisor(req_divisor), .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_div0(rsp_div0), .rsp_ovf(rsp_ovf),
    .core_start(core_start), .core_dividend_bn(core_dividend_bn),
    .core_divisor_bn(core_divisor_bn), .core_dividend(core_dividend),
    .core_cycle_num(core_cycle_num), .core_pass_flag(core_pass_flag),
    .core_zero_flag_divisor(core_zero_flag_divisor),
    .core_dividend_sign(core_dividend_sign), .core_divisor_sign(core_divisor_sign),
    .core_divisor_bit(core_divisor_bit),
    .core_q(core_q), .core_r(core_r), .core_done(core_done), .core_free(core_free)
  );

  assign outs_any = |{core_start, core_dividend_bn, core_divisor_bn, core_dividend,
                      core_cycle_num, core_pass_flag, core_zero_flag_divisor,
                      core_dividend_sign, core_divisor_sign, core_divisor_bit,
                      rsp_valid, rsp_q, rsp_r, rsp_div0, rsp_ovf};

  typedef struct {
    logic [31:0] dd, dv;
    logic        sg;
    bit          is_local;
    logic [6:0]  dbit;
    logic [5:0]  cn;
    logic [32:0] dvbn;
    logic [31:0] ddbn;
    logic        pass, sd, sv;
    logic [31:0] sq, sr;
    int          dly, soff;
    logic [31:0] q, r;
    logic        d0, ov;
  } vec_t;

  vec_t exp_core[$];
  int   exp_start[$];
  vec_t exp_rsp[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int starts = 0;
  int exp_vcyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] dd, dv, input logic sg, input bit loc,
                              input logic [6:0] dbit, input logic [5:0] cn,
                              input logic [32:0] dvbn, input logic [31:0] ddbn,
                              input logic pass, sd, sv, input logic [31:0] sq, sr,
                              input int dly, soff, input logic [31:0] q, r,
                              input logic d0, ov);
    vec_t v;
    v.dd = dd; v.dv = dv; v.sg = sg; v.is_local = loc; v.dbit = dbit; v.cn = cn;
    v.dvbn = dvbn; v.ddbn = ddbn; v.pass = pass; v.sd = sd; v.sv = sv;
    v.sq = sq; v.sr = sr; v.dly = dly; v.soff = soff; v.q = q; v.r = r; v.d0 = d0; v.ov = ov;
    return v;
  endfunction

  task automatic send(input vec_t v, output int acc);
    int guard = 0;
    @(posedge clk); #1;
    req_dividend = v.dd;
    req_divisor  = v.dv;
    req_signed   = v.sg;
    req_valid    = 1'b1;
    while (req_ready !== 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("req_accept_in_time", req_ready, 1);
    acc = cyc;
    if (v.is_local) exp_vcyc = cyc + 2;
    else begin
      exp_core.push_back(v);
      exp_start.push_back(cyc + v.soff);
    end
    exp_rsp.push_back(v);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (exp_rsp.size() != 0 && g < 300) begin
      @(posedge clk);
      g++;
    end
    chk("response_drained", exp_rsp.size(), 0);
    @(posedge clk); #1;
  endtask

  // Core stub: checks the issued fields, then returns the vector's canned result.
  initial begin
    vec_t v;
    int s;
    core_done = 1'b0;
    core_q = '0;
    core_r = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        starts++;
        chk("core_start_expected", exp_core.size() > 0, 1);
        if (exp_core.size() > 0) begin
          v = exp_core.pop_front();
          s = exp_start.pop_front();
          chk("start_cycle", cyc, s);
          chk("core_divisor_bit", core_divisor_bit, v.dbit);
          chk("core_cycle_num", core_cycle_num, v.cn);
          chk("core_divisor_bn", core_divisor_bn, v.dvbn);
          chk("core_dividend_bn", core_dividend_bn, v.ddbn);
          chk("core_pass_flag", core_pass_flag, v.pass);
          chk("core_dividend", core_dividend, v.dd);
          chk("core_zero_flag_divisor", core_zero_flag_divisor, 1);
          chk("core_signs", {core_dividend_sign, core_divisor_sign}, {v.sd, v.sv});
          repeat (v.dly) @(posedge clk);
          #1;
          core_done = 1'b1;
          core_q    = v.sq;
          core_r    = v.sr;
          exp_vcyc  = cyc + 1;
          @(posedge clk); #1;
          core_done = 1'b0;
        end
      end
    end
  end

  // Response monitor: latency on first valid, stability while stalled, values on handshake.
  initial begin
    bit          prev_v;
    logic [31:0] hq, hr;
    logic        hd, ho;
    vec_t        e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) prev_v = 1'b0;
      else if (rsp_valid === 1'b1) begin
        if (!prev_v) begin
          chk("rsp_expected", exp_rsp.size() > 0, 1);
          if (exp_rsp.size() > 0) chk("rsp_latency", cyc, exp_vcyc);
          hq = rsp_q; hr = rsp_r; hd = rsp_div0; ho = rsp_ovf;
        end else begin
          chk("rsp_stable", {rsp_q, rsp_r, rsp_div0, rsp_ovf} == {hq, hr, hd, ho}, 1);
        end
        prev_v = 1'b1;
        if (rsp_ready === 1'b1) begin
          prev_v = 1'b0;
          if (exp_rsp.size() > 0) begin
            e = exp_rsp.pop_front();
            chk("rsp_q", rsp_q, e.q);
            chk("rsp_r", rsp_r, e.r);
            chk("rsp_div0", rsp_div0, e.d0);
            chk("rsp_ovf", rsp_ovf, e.ov);
          end
        end
      end else prev_v = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int a, g, s0;
    rst_n = 1'b0; req_valid = 1'b0; req_dividend = '0; req_divisor = '0; req_signed = 1'b0;
    rsp_ready = 1'b1; core_free = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs_zero", outs_any, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", req_ready, 1);

    // unsigned 100 / 7
    v = mk(100, 7, 0, 0, 29, 5, 33'h0E0000000, 32'h32000000, 0, 0, 0, 14, 2, 3, 2, 14, 2, 0, 0);
    send(v, a); wait_done();
    // unsigned 5 / 9: dividend below divisor
    v = mk(5, 9, 0, 0, 28, 0, 33'h090000000, 32'h28000000, 1, 0, 0, 0, 5, 3, 2, 0, 5, 0, 0);
    send(v, a); wait_done();
    // divide by zero, answered locally
    v = mk(32'h1234, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h1234, 1, 0);
    send(v, a); wait_done();
    // signed overflow, answered locally
    v = mk(32'h80000000, 32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80000000, 0, 0, 1);
    send(v, a); wait_done();
    // signed -100 / 7
    v = mk(32'hFFFFFF9C, 7, 1, 0, 29, 5, 33'h0E0000000, 32'h32000000, 0, 1, 0,
           32'hFFFFFFF2, 32'hFFFFFFFE, 3, 2, 32'hFFFFFFF2, 32'hFFFFFFFE, 0, 0);
    send(v, a); wait_done();

    // core busy for 10 cycles, then response stalled by rsp_ready
    core_free = 1'b0;
    rsp_ready = 1'b0;
    v = mk(1000, 10, 0, 0, 28, 7, 33'h0A0000000, 32'h3E800000, 0, 0, 0, 100, 0, 3, 12, 100, 0, 0, 0);
    send(v, a);
    repeat ((a + 12) - cyc) @(posedge clk);
    #1;
    core_free = 1'b1;
    g = 0;
    @(negedge clk);
    while (rsp_valid !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("stall_rsp_valid_seen", rsp_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_done();

    // reset during WAIT; the core's later done must be ignored
    s0 = starts;
    v = mk(50, 3, 0, 0, 30, 5, 33'h0C0000000, 32'h32000000, 0, 0, 0, 16, 2, 10, 2, 16, 2, 0, 0);
    send(v, a);
    g = 0;
    while (starts == s0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("abort_start_seen", starts, s0 + 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_reset_outs_zero", outs_any, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_rsp.delete();
    @(negedge clk);
    chk("req_ready_after_midop_reset", req_ready, 1);
    chk("outs_zero_after_midop_reset", outs_any, 0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("stale_done_no_rsp", rsp_valid, 0);
    chk("stale_done_still_idle", req_ready, 1);

    // fresh request after reset: 7 / 7
    v = mk(7, 7, 0, 0, 29, 1, 33'h0E0000000, 32'h38000000, 0, 0, 0, 1, 0, 3, 2, 1, 0, 0, 0);
    send(v, a); wait_done();

    chk("core_start_count", starts, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
